// File: rtl/pattern_gen.sv
// Programmable serial pattern transmitter: sends a captured pattern MSB-first,
// repeated rep_cnt times with gap_len idle cycles between frames.
module pattern_gen #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int REP_W   = 4,
  parameter int GAP_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic [REP_W-1:0]   rep_cnt,
  input  logic [GAP_W-1:0]   gap_len,
  output logic               ready,
  output logic               data_out,
  output logic               data_valid,
  output logic               frame_start,
  output logic               done
);

  localparam int IDX_W = $clog2(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [MAX_LEN-1:0] r_pat;
  logic [IDX_W-1:0]   r_top_idx;
  logic [IDX_W-1:0]   r_bit_idx;
  logic [REP_W-1:0]   r_rep_left;
  logic [GAP_W-1:0]   r_gap;
  logic [GAP_W-1:0]   r_gap_cnt;

  state_t             w_state_d;
  logic [MAX_LEN-1:0] w_pat_d;
  logic [IDX_W-1:0]   w_top_idx_d;
  logic [IDX_W-1:0]   w_bit_idx_d;
  logic [REP_W-1:0]   w_rep_left_d;
  logic [GAP_W-1:0]   w_gap_d;
  logic [GAP_W-1:0]   w_gap_cnt_d;
  logic               w_valid_d;
  logic               w_fs_d;
  logic               w_done_d;
  logic               w_bit_d;
  logic               w_ready_d;

  logic [LEN_W-1:0]   w_len_c;
  logic [REP_W-1:0]   w_rep_c;
  logic [IDX_W-1:0]   w_top_c;

  // Command sanitising: oversize lengths clamp, a zero repeat count means one frame.
  assign w_len_c = (pat_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : pat_len;
  assign w_rep_c = (rep_cnt == '0) ? REP_W'(1) : rep_cnt;
  assign w_top_c = IDX_W'(w_len_c - LEN_W'(1));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missed assignment here would infer a latch.
    w_state_d    = r_state;
    w_pat_d      = r_pat;
    w_top_idx_d  = r_top_idx;
    w_bit_idx_d  = r_bit_idx;
    w_rep_left_d = r_rep_left;
    w_gap_d      = r_gap;
    w_gap_cnt_d  = r_gap_cnt;
    w_valid_d    = 1'b0;
    w_fs_d       = 1'b0;
    w_done_d     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_pat_d      = pat_in;
          w_gap_d      = gap_len;
          w_gap_cnt_d  = '0;
          w_rep_left_d = w_rep_c - REP_W'(1);
          if (w_len_c == '0) begin
            w_state_d = S_DONE;
            w_done_d  = 1'b1;
          end else begin
            w_state_d   = S_SEND;
            w_top_idx_d = w_top_c;
            w_bit_idx_d = w_top_c;
            w_valid_d   = 1'b1;
            w_fs_d      = 1'b1;
          end
        end
      end

      S_SEND: begin
        if (r_bit_idx != '0) begin
          w_bit_idx_d = r_bit_idx - IDX_W'(1);
          w_valid_d   = 1'b1;
        end else if (r_rep_left != '0) begin
          if (r_gap != '0) begin
            w_state_d   = S_GAP;
            w_gap_cnt_d = r_gap - GAP_W'(1);
          end else begin
            w_bit_idx_d  = r_top_idx;
            w_rep_left_d = r_rep_left - REP_W'(1);
            w_valid_d    = 1'b1;
            w_fs_d       = 1'b1;
          end
        end else begin
          w_state_d = S_DONE;
          w_done_d  = 1'b1;
        end
      end

      S_GAP: begin
        // r_gap_cnt holds the idle cycles still owed after the current one.
        if (r_gap_cnt != '0) begin
          w_gap_cnt_d = r_gap_cnt - GAP_W'(1);
        end else begin
          w_state_d    = S_SEND;
          w_bit_idx_d  = r_top_idx;
          w_rep_left_d = r_rep_left - REP_W'(1);
          w_valid_d    = 1'b1;
          w_fs_d       = 1'b1;
        end
      end

      S_DONE: begin
        w_state_d = S_IDLE;
      end

      default: begin
        w_state_d = S_IDLE;
      end
    endcase

    // Bit comes from the next-cycle pattern so the first bit is correct on acceptance.
    w_bit_d   = w_valid_d & w_pat_d[w_bit_idx_d];
    w_ready_d = (w_state_d == S_IDLE);
  end

  // NOTE: state and outputs are updated with non-blocking assignments so every
  // register samples the values from before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pat       <= '0;
      r_top_idx   <= '0;
      r_bit_idx   <= '0;
      r_rep_left  <= '0;
      r_gap       <= '0;
      r_gap_cnt   <= '0;
      ready       <= 1'b1;
      data_out    <= 1'b0;
      data_valid  <= 1'b0;
      frame_start <= 1'b0;
      done        <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_pat       <= w_pat_d;
      r_top_idx   <= w_top_idx_d;
      r_bit_idx   <= w_bit_idx_d;
      r_rep_left  <= w_rep_left_d;
      r_gap       <= w_gap_d;
      r_gap_cnt   <= w_gap_cnt_d;
      ready       <= w_ready_d;
      data_out    <= w_bit_d;
      data_valid  <= w_valid_d;
      frame_start <= w_fs_d;
      done        <= w_done_d;
    end
  end

endmodule

// File: tb/tb_pattern_gen.sv
// Self-checking bench for pattern_gen: directed and random commands compared
// cycle by cycle against a frame-level reference model.
module tb_pattern_gen;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int REP_W   = 4;
  localparam int GAP_W   = 4;

  // Idle observation: {valid, data, frame_start, done, ready}
  localparam logic [4:0] IDLE_OBS = 5'b0000_1;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [MAX_LEN-1:0] pat_in;
  logic [LEN_W-1:0]   pat_len;
  logic [REP_W-1:0]   rep_cnt;
  logic [GAP_W-1:0]   gap_len;
  logic               ready;
  logic               data_out;
  logic               data_valid;
  logic               frame_start;
  logic               done;

  int n_cmp = 0;
  int n_err = 0;

  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  pattern_gen #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W),
    .REP_W  (REP_W),
    .GAP_W  (GAP_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pat_in     (pat_in),
    .pat_len    (pat_len),
    .rep_cnt    (rep_cnt),
    .gap_len    (gap_len),
    .ready      (ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_start(frame_start),
    .done       (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] observe();
    return {data_valid, data_out, frame_start, done, ready};
  endfunction

  // Reference: per-cycle expectation list starting the cycle after acceptance.
  task automatic build_model(input logic [MAX_LEN-1:0] pat, input int len, input int rep,
                             input int gap);
    int len_e;
    int rep_e;
    len_e = (len > MAX_LEN) ? MAX_LEN : len;
    rep_e = (rep == 0) ? 1 : rep;
    exp_q.delete();
    if (len_e != 0) begin
      for (int r = 0; r < rep_e; r++) begin
        for (int b = len_e - 1; b >= 0; b--)
          exp_q.push_back({1'b1, pat[b], (b == len_e - 1), 1'b0, 1'b0});
        if (r < rep_e - 1)
          for (int g = 0; g < gap; g++) exp_q.push_back(5'b0000_0);
      end
    end
    exp_q.push_back(5'b0001_0);
  endtask

  // Issues one command and checks every cycle; abort_after>0 stops after that many cycles.
  task automatic run_frame(input string name, input logic [MAX_LEN-1:0] pat, input int len,
                           input int rep, input int gap, input bit noise, input int abort_after);
    int waited;
    logic [4:0] obs;
    waited = 0;
    while (ready !== 1'b1 && waited < 64) begin
      tick();
      waited++;
    end
    n_cmp++;
    if (ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s ready_wait: got %b want 1 after %0d cycles", name, ready, waited);
      return;
    end
    build_model(pat, len, rep, gap);
    pat_in  = pat;
    pat_len = LEN_W'(len);
    rep_cnt = REP_W'(rep);
    gap_len = GAP_W'(gap);
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = observe();
      n_cmp++;
      if (obs !== exp_q[i]) begin
        n_err++;
        $display("FAIL %s cycle %0d: got v/d/fs/done/rdy=%b want %b", name, i, obs, exp_q[i]);
      end
      if (abort_after > 0 && i == abort_after - 1) return;
      if (noise && i < exp_q.size() - 1) begin
        start   = 1'($urandom_range(0, 1));
        pat_in  = MAX_LEN'($urandom);
        pat_len = LEN_W'($urandom);
        rep_cnt = REP_W'($urandom);
        gap_len = GAP_W'($urandom);
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    obs = observe();
    n_cmp++;
    if (obs !== IDLE_OBS) begin
      n_err++;
      $display("FAIL %s after_done: got %b want %b", name, obs, IDLE_OBS);
    end
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    rst = 1'b1;
    start = 1'b1;
    pat_in = 8'hFF;
    pat_len = 4'd4;
    rep_cnt = 4'd1;
    gap_len = 4'd0;
    repeat (3) tick();
    obs = observe();
    n_cmp++;
    if (obs !== IDLE_OBS) begin
      n_err++;
      $display("FAIL reset_hold: got %b want %b", obs, IDLE_OBS);
    end
    start = 1'b0;
    rst = 1'b0;
    tick();
    obs = observe();
    n_cmp++;
    if (obs !== IDLE_OBS) begin
      n_err++;
      $display("FAIL reset_release: got %b want %b", obs, IDLE_OBS);
    end
  endtask

  task automatic test_basic();
    run_frame("basic", 8'b0001_0110, 5, 1, 0, 1'b0, 0);
  endtask

  task automatic test_repeat_gap();
    run_frame("repeat_gap", 8'b0001_0110, 5, 3, 2, 1'b0, 0);
    run_frame("repeat_nogap", 8'b1100_1010, 4, 3, 0, 1'b0, 0);
  endtask

  task automatic test_zero_fields();
    run_frame("len_zero", 8'hFF, 0, 2, 3, 1'b0, 0);
    run_frame("rep_zero", 8'b0000_0101, 3, 0, 4, 1'b0, 0);
  endtask

  task automatic test_clamp();
    run_frame("clamp", 8'hA5, 12, 1, 0, 1'b0, 0);
  endtask

  task automatic test_busy_ignore();
    run_frame("busy_ignore", 8'b0110_1001, 7, 2, 1, 1'b1, 0);
  endtask

  task automatic test_reset_mid();
    logic [4:0] obs;
    run_frame("rst_mid", 8'b0001_0110, 5, 1, 0, 1'b0, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      obs = observe();
      n_cmp++;
      if (obs !== IDLE_OBS) begin
        n_err++;
        $display("FAIL rst_mid_idle cycle %0d: got %b want %b", i, obs, IDLE_OBS);
      end
      tick();
    end
    run_frame("rst_mid_fresh", 8'b1011_0011, 8, 2, 1, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    run_frame("b2b_a", 8'h3C, 6, 1, 0, 1'b0, 0);
    run_frame("b2b_b", 8'h81, 8, 2, 0, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      run_frame($sformatf("random_%0d", n), MAX_LEN'($urandom), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_repeat_gap();
    test_zero_fields();
    test_clamp();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
